// File: rtl/multi_alarm_pkg.sv
// multi_alarm_pkg: shared types and constants for the multi-channel alarm.
//   - time_field_t : 7-bit binary hour/minute/second field
//   - ch_state_e   : per-channel state (SNOOZE exists only with MULTI_ALARM_SNOOZE_EN)
//   - HourMax / MinSecMax : largest legal hour (23) and minute/second (59)
//   - time_valid() : range check of a written time
//   - add_minutes(): hour:minute plus a small minute offset, wrapping at midnight
// Optional feature macro: MULTI_ALARM_SNOOZE_EN.
package multi_alarm_pkg;

  typedef logic [6:0] time_field_t;

  localparam time_field_t HourMax   = 7'd23;
  localparam time_field_t MinSecMax = 7'd59;

`ifdef MULTI_ALARM_SNOOZE_EN
  typedef enum logic [1:0] {
    ChIdle    = 2'd0,
    ChRinging = 2'd1,
    ChSnooze  = 2'd2
  } ch_state_e;
`else
  typedef enum logic [1:0] {
    ChIdle    = 2'd0,
    ChRinging = 2'd1
  } ch_state_e;
`endif

  function automatic logic time_valid(input time_field_t h, input time_field_t m,
                                      input time_field_t s);
    return (h <= HourMax) && (m <= MinSecMax) && (s <= MinSecMax);
  endfunction

  // Returns {hour, minute}; delta must not exceed 60.
  function automatic logic [13:0] add_minutes(input time_field_t h, input time_field_t m,
                                              input int unsigned delta);
    logic [7:0]  m_sum;
    time_field_t h_new;
    time_field_t m_new;
    m_sum = {1'b0, m} + 8'(delta);
    if (m_sum > {1'b0, MinSecMax}) begin
      m_new = 7'(m_sum - 8'd60);
      h_new = (h == HourMax) ? 7'd0 : h + 7'd1;
    end else begin
      m_new = m_sum[6:0];
      h_new = h;
    end
    return {h_new, m_new};
  endfunction

endpackage

// File: rtl/multi_alarm_channel.sv
// alarm_channel: one alarm channel (stored time, armed flag, IDLE/RINGING[/SNOOZE]).
// Ports:
//   clk, reset        : clock, synchronous active-low reset
//   sec_tick          : one-cycle pulse per second
//   hour/min/sec      : current time
//   wr                : validated write addressed to this channel (wins over everything)
//   wr_hour/min/sec   : alarm time to load; wr_arm: armed flag to load
//   stop_hit          : stop edge aimed at this channel (it is the reported ring_ch)
//   snooze_hit        : snooze edge aimed at this channel (MULTI_ALARM_SNOOZE_EN only)
//   stop_idle         : stop edge while nothing rings (MULTI_ALARM_SNOOZE_EN only)
//   armed             : stored armed flag
//   ringing_nxt       : channel will be RINGING after this edge (feeds registered outputs)
// Optional feature macro: MULTI_ALARM_SNOOZE_EN.
module alarm_channel
  import multi_alarm_pkg::*;
#(
  parameter int unsigned RING_SECS  = 60,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic [6:0] hour,
  input  logic [6:0] min,
  input  logic [6:0] sec,
  input  logic       wr,
  input  logic [6:0] wr_hour,
  input  logic [6:0] wr_min,
  input  logic [6:0] wr_sec,
  input  logic       wr_arm,
  input  logic       stop_hit,
`ifdef MULTI_ALARM_SNOOZE_EN
  input  logic       snooze_hit,
  input  logic       stop_idle,
`endif
  output logic       armed,
  output logic       ringing_nxt
);

  ch_state_e   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  time_field_t al_hour_q, al_hour_d;
  time_field_t al_min_q, al_min_d;
  time_field_t al_sec_q, al_sec_d;
  logic        armed_q, armed_d;
  logic        alarm_match;

`ifdef MULTI_ALARM_SNOOZE_EN
  // Wake time: the time this ring started at; each snooze pushes it forward.
  time_field_t wk_hour_q, wk_hour_d;
  time_field_t wk_min_q, wk_min_d;
  time_field_t wk_sec_q, wk_sec_d;
  logic        wake_match;

  assign wake_match = sec_tick && (hour == wk_hour_q) && (min == wk_min_q) && (sec == wk_sec_q);
`endif

  assign alarm_match = sec_tick && armed_q &&
                       (hour == al_hour_q) && (min == al_min_q) && (sec == al_sec_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    al_hour_d = al_hour_q;
    al_min_d  = al_min_q;
    al_sec_d  = al_sec_q;
    armed_d   = armed_q;
`ifdef MULTI_ALARM_SNOOZE_EN
    wk_hour_d = wk_hour_q;
    wk_min_d  = wk_min_q;
    wk_sec_d  = wk_sec_q;
`endif
    if (wr) begin
      state_d   = ChIdle;
      cnt_d     = '0;
      al_hour_d = wr_hour;
      al_min_d  = wr_min;
      al_sec_d  = wr_sec;
      armed_d   = wr_arm;
    end else begin
      case (state_q)
        ChIdle: begin
          if (alarm_match) begin
            state_d = ChRinging;
            cnt_d   = '0;
`ifdef MULTI_ALARM_SNOOZE_EN
            wk_hour_d = al_hour_q;
            wk_min_d  = al_min_q;
            wk_sec_d  = al_sec_q;
`endif
          end
        end
        ChRinging: begin
          if (stop_hit) begin
            state_d = ChIdle;
            cnt_d   = '0;
`ifdef MULTI_ALARM_SNOOZE_EN
          end else if (snooze_hit) begin
            state_d = ChSnooze;
            cnt_d   = '0;
            {wk_hour_d, wk_min_d} = add_minutes(wk_hour_q, wk_min_q, SNOOZE_MIN);
`endif
          end else if (sec_tick) begin
            if (cnt_q == 8'(RING_SECS - 1)) begin
              state_d = ChIdle;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
`ifdef MULTI_ALARM_SNOOZE_EN
        ChSnooze: begin
          if (stop_idle) begin
            state_d = ChIdle;
          end else if (wake_match) begin
            state_d = ChRinging;
            cnt_d   = '0;
          end
        end
`endif
        default: state_d = ChIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ChIdle;
      cnt_q     <= '0;
      al_hour_q <= '0;
      al_min_q  <= '0;
      al_sec_q  <= '0;
      armed_q   <= 1'b0;
`ifdef MULTI_ALARM_SNOOZE_EN
      wk_hour_q <= '0;
      wk_min_q  <= '0;
      wk_sec_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      al_hour_q <= al_hour_d;
      al_min_q  <= al_min_d;
      al_sec_q  <= al_sec_d;
      armed_q   <= armed_d;
`ifdef MULTI_ALARM_SNOOZE_EN
      wk_hour_q <= wk_hour_d;
      wk_min_q  <= wk_min_d;
      wk_sec_q  <= wk_sec_d;
`endif
    end
  end

  assign armed       = armed_q;
  assign ringing_nxt = (state_d == ChRinging);

endmodule

// File: rtl/multi_alarm.sv
// multi_alarm: N_CH independent alarm channels sharing one time base.
// Ports:
//   clk, reset           : clock, synchronous active-low reset
//   sec_tick             : one-cycle pulse per second; hour/min/sec: current time
//   wr_en, wr_ch         : channel setup strobe and target channel
//   wr_hour/min/sec, wr_arm : time and armed flag to store (ignored if out of range)
//   stop, snooze         : key levels; rising edges act on the reported ring_ch
//   ring, ring_ch        : registered "any channel ringing" and lowest ringing index
//   armed_mask           : per-channel armed flags
// Optional feature macro: MULTI_ALARM_SNOOZE_EN (snooze support; input ignored otherwise).
module multi_alarm
  import multi_alarm_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned RING_SECS  = 60,
  parameter int unsigned SNOOZE_MIN = 5,
  localparam int unsigned ChW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sec_tick,
  input  logic [6:0]      hour,
  input  logic [6:0]      min,
  input  logic [6:0]      sec,
  input  logic            wr_en,
  input  logic [ChW-1:0]  wr_ch,
  input  logic [6:0]      wr_hour,
  input  logic [6:0]      wr_min,
  input  logic [6:0]      wr_sec,
  input  logic            wr_arm,
  input  logic            stop,
  input  logic            snooze,
  output logic            ring,
  output logic [ChW-1:0]  ring_ch,
  output logic [N_CH-1:0] armed_mask
);

  logic            stop_q;
  logic            stop_rise;
  logic            wr_valid;
  logic [N_CH-1:0] ringing_nxt;
  logic            ring_q, ring_d;
  logic [ChW-1:0]  ring_ch_q, ring_ch_d;

  assign stop_rise = stop && !stop_q;
  assign wr_valid  = wr_en && time_valid(wr_hour, wr_min, wr_sec);

`ifdef MULTI_ALARM_SNOOZE_EN
  logic snooze_q;
  logic snooze_rise;
  logic stop_idle;

  // Stop wins over a simultaneous snooze edge.
  assign snooze_rise = snooze && !snooze_q && !stop_rise;
  assign stop_idle   = stop_rise && !ring_q;
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic sel_wr;
    logic is_ring_ch;

    assign sel_wr     = wr_valid && (wr_ch == ChW'(i));
    // ring_q/ring_ch_q mirror the current channel states, so they name the target.
    assign is_ring_ch = ring_q && (ring_ch_q == ChW'(i));

    alarm_channel #(
      .RING_SECS (RING_SECS),
      .SNOOZE_MIN(SNOOZE_MIN)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .sec_tick   (sec_tick),
      .hour       (hour),
      .min        (min),
      .sec        (sec),
      .wr         (sel_wr),
      .wr_hour    (wr_hour),
      .wr_min     (wr_min),
      .wr_sec     (wr_sec),
      .wr_arm     (wr_arm),
      .stop_hit   (stop_rise && is_ring_ch),
`ifdef MULTI_ALARM_SNOOZE_EN
      .snooze_hit (snooze_rise && is_ring_ch),
      .stop_idle  (stop_idle),
`endif
      .armed      (armed_mask[i]),
      .ringing_nxt(ringing_nxt[i])
    );
  end

  // Priority encoder on next-state so the outputs are registered alongside the states.
  always_comb begin
    ring_d    = |ringing_nxt;
    ring_ch_d = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (ringing_nxt[i]) ring_ch_d = ChW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stop_q    <= 1'b0;
      ring_q    <= 1'b0;
      ring_ch_q <= '0;
`ifdef MULTI_ALARM_SNOOZE_EN
      snooze_q  <= 1'b0;
`endif
    end else begin
      stop_q    <= stop;
      ring_q    <= ring_d;
      ring_ch_q <= ring_ch_d;
`ifdef MULTI_ALARM_SNOOZE_EN
      snooze_q  <= snooze;
`endif
    end
  end

  assign ring    = ring_q;
  assign ring_ch = ring_ch_q;

endmodule

// File: tb/tb_multi_alarm.sv
module tb_multi_alarm;

  localparam int NCh       = 4;
  localparam int RingSecs  = 3;
  localparam int SnoozeMin = 5;
`ifdef MULTI_ALARM_SNOOZE_EN
  localparam bit SnzEn = 1'b1;
`else
  localparam bit SnzEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sec_tick = 1'b0;
  logic [6:0] hour = '0, min = '0, sec = '0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_ch = '0;
  logic [6:0] wr_hour = '0, wr_min = '0, wr_sec = '0;
  logic       wr_arm = 1'b0;
  logic       stop = 1'b0, snooze = 1'b0;
  logic       ring;
  logic [1:0] ring_ch;
  logic [3:0] armed_mask;

  int n_checks = 0;
  int n_pass   = 0;

  multi_alarm #(
    .N_CH      (NCh),
    .RING_SECS (RingSecs),
    .SNOOZE_MIN(SnoozeMin)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sec_tick  (sec_tick),
    .hour      (hour),
    .min       (min),
    .sec       (sec),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_hour   (wr_hour),
    .wr_min    (wr_min),
    .wr_sec    (wr_sec),
    .wr_arm    (wr_arm),
    .stop      (stop),
    .snooze    (snooze),
    .ring      (ring),
    .ring_ch   (ring_ch),
    .armed_mask(armed_mask)
  );

  always #5 clk = ~clk;

  // Reference model: times held as seconds-of-day, states as small integers.
  localparam int StIdle = 0, StRing = 1, StSnz = 2;
  int   m_alarm[NCh];
  bit   m_armed[NCh];
  int   m_st[NCh];
  int   m_cnt[NCh];
  int   m_base[NCh];
  int   m_wake[NCh];
  bit   m_stop_prev, m_snz_prev;
  logic       m_ring = 1'b0;
  logic [1:0] m_ring_ch = '0;
  logic [3:0] m_mask = '0;

  task automatic model_step();
    int now;
    bit stop_r, snz_r, cur_ring, wr_ok;
    int cur_ch;
    if (!reset) begin
      for (int c = 0; c < NCh; c++) begin
        m_alarm[c] = 0; m_armed[c] = 0; m_st[c] = StIdle; m_cnt[c] = 0;
        m_base[c] = 0; m_wake[c] = 0;
      end
      m_stop_prev = 0; m_snz_prev = 0;
      m_ring = 0; m_ring_ch = 0; m_mask = 0;
      return;
    end
    stop_r = stop && !m_stop_prev;
    snz_r  = SnzEn && snooze && !m_snz_prev && !stop_r;
    m_stop_prev = stop; m_snz_prev = snooze;
    cur_ring = m_ring;
    cur_ch   = int'(m_ring_ch);
    now   = int'(hour) * 3600 + int'(min) * 60 + int'(sec);
    wr_ok = wr_en && wr_hour <= 23 && wr_min <= 59 && wr_sec <= 59;
    for (int c = 0; c < NCh; c++) begin
      if (wr_ok && int'(wr_ch) == c) begin
        m_alarm[c] = int'(wr_hour) * 3600 + int'(wr_min) * 60 + int'(wr_sec);
        m_armed[c] = wr_arm; m_st[c] = StIdle; m_cnt[c] = 0;
      end else if (m_st[c] == StRing) begin
        if (stop_r && cur_ring && c == cur_ch) m_st[c] = StIdle;
        else if (snz_r && cur_ring && c == cur_ch) begin
          m_st[c] = StSnz;
          m_wake[c] = (m_base[c] + SnoozeMin * 60) % 86400;
        end else if (sec_tick) begin
          m_cnt[c]++;
          if (m_cnt[c] >= RingSecs) begin m_st[c] = StIdle; m_cnt[c] = 0; end
        end
      end else if (m_st[c] == StSnz) begin
        if (stop_r && !cur_ring) m_st[c] = StIdle;
        else if (sec_tick && now == m_wake[c]) begin
          m_st[c] = StRing; m_cnt[c] = 0; m_base[c] = m_wake[c];
        end
      end else if (sec_tick && m_armed[c] && now == m_alarm[c]) begin
        m_st[c] = StRing; m_cnt[c] = 0; m_base[c] = m_alarm[c];
      end
    end
    m_ring = 0; m_ring_ch = 0;
    for (int c = 0; c < NCh; c++) begin
      m_mask[c] = m_armed[c];
      if (m_st[c] == StRing && !m_ring) begin m_ring = 1; m_ring_ch = 2'(c); end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_write(input int ch, input int h, input int m, input int s, input bit arm);
    wr_en = 1; wr_ch = 2'(ch); wr_hour = 7'(h); wr_min = 7'(m); wr_sec = 7'(s); wr_arm = arm;
    cycle();
    wr_en = 0;
  endtask

  task automatic tick_at(input int h, input int m, input int s);
    hour = 7'(h); min = 7'(m); sec = 7'(s); sec_tick = 1;
    cycle();
    sec_tick = 0;
  endtask

  task automatic press_stop();
    stop = 1; cycle(); stop = 0; cycle();
  endtask

  task automatic test_reset();
    reset = 0;
    cycle(); cycle();
    n_checks++;
    if ({ring, ring_ch, armed_mask} !== 7'b0) $display("FAIL reset_outputs: got %b want 0",
                                                       {ring, ring_ch, armed_mask});
    else n_pass++;
    reset = 1;
    cycle();
  endtask

  task automatic test_basic();
    do_write(0, 7, 30, 0, 1);
    n_checks++;
    if (armed_mask !== m_mask || armed_mask !== 4'b0001)
      $display("FAIL basic_armed: got %b want %b", armed_mask, m_mask);
    else n_pass++;
    tick_at(7, 30, 0);
    n_checks++;
    if (ring !== 1'b1 || ring_ch !== 2'd0 || ring !== m_ring)
      $display("FAIL basic_ring: got ring=%b ch=%0d want ring=1 ch=0", ring, ring_ch);
    else n_pass++;
    press_stop();
    n_checks++;
    if (ring !== 1'b0 || ring !== m_ring) $display("FAIL basic_stop: got %b want 0", ring);
    else n_pass++;
  endtask

  task automatic test_autostop();
    do_write(2, 2, 0, 0, 1);
    tick_at(2, 0, 0);
    for (int t = 1; t <= RingSecs; t++) begin
      tick_at(2, 0, t);
      n_checks++;
      if (ring !== m_ring || ring !== (t < RingSecs))
        $display("FAIL autostop_tick%0d: got %b want %b", t, ring, m_ring);
      else n_pass++;
    end
    n_checks++;
    if (armed_mask[2] !== 1'b1 || armed_mask !== m_mask)
      $display("FAIL autostop_armed: got %b want %b", armed_mask, m_mask);
    else n_pass++;
  endtask

  task automatic test_priority();
    do_write(1, 12, 0, 0, 1);
    do_write(3, 12, 0, 0, 1);
    tick_at(12, 0, 0);
    n_checks++;
    if (ring !== 1'b1 || ring_ch !== 2'd1 || ring_ch !== m_ring_ch)
      $display("FAIL prio_both: got ring=%b ch=%0d want ring=1 ch=1", ring, ring_ch);
    else n_pass++;
    press_stop();
    n_checks++;
    if (ring !== 1'b1 || ring_ch !== 2'd3 || ring_ch !== m_ring_ch)
      $display("FAIL prio_stop1: got ring=%b ch=%0d want ring=1 ch=3", ring, ring_ch);
    else n_pass++;
    press_stop();
    n_checks++;
    if (ring !== 1'b0 || ring_ch !== 2'd0 || ring !== m_ring)
      $display("FAIL prio_stop2: got ring=%b ch=%0d want ring=0 ch=0", ring, ring_ch);
    else n_pass++;
  endtask

  task automatic test_snooze();
    do_write(0, 23, 58, 10, 1);
    tick_at(23, 58, 10);
    snooze = 1; cycle(); snooze = 0;
    n_checks++;
    if (ring !== m_ring || ring !== !SnzEn)
      $display("FAIL snooze_press: got %b want %b", ring, m_ring);
    else n_pass++;
    tick_at(0, 3, 9);
    tick_at(0, 3, 10);
    n_checks++;
    if (ring !== 1'b1 || ring_ch !== 2'd0 || ring !== m_ring)
      $display("FAIL snooze_wake: got ring=%b ch=%0d want ring=1 ch=0", ring, ring_ch);
    else n_pass++;
    press_stop();
    n_checks++;
    if (ring !== 1'b0 || ring !== m_ring) $display("FAIL snooze_stop: got %b want 0", ring);
    else n_pass++;
  endtask

  task automatic test_reset_midring();
    do_write(1, 1, 0, 0, 1);
    tick_at(1, 0, 0);
    n_checks++;
    if (ring !== 1'b1 || ring !== m_ring) $display("FAIL midring_pre: got %b want 1", ring);
    else n_pass++;
    reset = 0; cycle(); reset = 1;
    n_checks++;
    if ({ring, ring_ch, armed_mask} !== 7'b0 || armed_mask !== m_mask)
      $display("FAIL midring_reset: got %b want 0", {ring, ring_ch, armed_mask});
    else n_pass++;
    do_write(2, 5, 6, 7, 1);
    do_write(2, 5, 60, 7, 0);
    n_checks++;
    if (armed_mask !== 4'b0100 || armed_mask !== m_mask)
      $display("FAIL bad_write: got %b want 0100", armed_mask);
    else n_pass++;
    tick_at(5, 6, 7);
    n_checks++;
    if (ring !== 1'b1 || ring !== m_ring) $display("FAIL bad_write_kept: got %b want 1", ring);
    else n_pass++;
    press_stop();
  endtask

  task automatic test_random();
    int mins[3];
    mins[0] = 0; mins[1] = 5; mins[2] = 60;
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 99) != 0);
      sec_tick = $urandom_range(0, 1);
      hour     = 7'($urandom_range(0, 1));
      min      = 7'(mins[$urandom_range(0, 1)]);
      sec      = '0;
      wr_en    = ($urandom_range(0, 7) == 0);
      wr_ch    = 2'($urandom_range(0, 3));
      wr_hour  = 7'($urandom_range(0, 1));
      wr_min   = 7'(mins[$urandom_range(0, 2)]);
      wr_sec   = '0;
      wr_arm   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) stop = ~stop;
      if ($urandom_range(0, 5) == 0) snooze = ~snooze;
      cycle();
      n_checks++;
      if ({ring, ring_ch, armed_mask} !== {m_ring, m_ring_ch, m_mask})
        $display("FAIL random_cycle%0d: got ring=%b ch=%0d mask=%b want ring=%b ch=%0d mask=%b",
                 i, ring, ring_ch, armed_mask, m_ring, m_ring_ch, m_mask);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_autostop();
    test_priority();
    test_snooze();
    test_reset_midring();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_alarm.md
MULTI_ALARM -- requirements
Module: multi_alarm

Interface
REQ-001 Parameter N_CH, default 4: number of independent alarm channels, range 1..16.
REQ-002 Parameter RING_SECS, default 60: ring duration in sec_tick pulses before auto-stop, range 1..255.
REQ-003 Parameter SNOOZE_MIN, default 5: snooze delay in minutes, range 1..30.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 sec_tick  in  1  one-cycle pulse when the time inputs advance by one second.
REQ-007 hour/min/sec  in  7 each  current time, binary, 0..23 / 0..59 / 0..59.
REQ-008 wr_en  in  1  one-cycle write strobe for channel setup.
REQ-009 wr_ch  in  $clog2(N_CH) (min 1)  target channel of the write.
REQ-010 wr_hour/wr_min/wr_sec  in  7 each  alarm time to store.
REQ-011 wr_arm  in  1  armed flag stored with the write.
REQ-012 stop  in  1  level from keyunit; rising edge cancels the current ring.
REQ-013 snooze  in  1  level; rising edge snoozes the current ring.
REQ-014 ring  out  1  high while any channel is RINGING; drives music enable.
REQ-015 ring_ch  out  $clog2(N_CH)  lowest-index RINGING channel; 0 when ring is low.
REQ-016 armed_mask  out  N_CH  per-channel armed flags.

Function
REQ-017 Each channel SHALL hold alarm time, armed flag and state IDLE, RINGING or SNOOZE.
REQ-018 IDLE->RINGING when sec_tick=1, armed=1 and hour/min/sec equal the stored time.
REQ-019 Registered outputs: ring SHALL rise on the cycle after the matching sec_tick.
REQ-020 RINGING SHALL count sec_tick pulses; after RING_SECS pulses the channel SHALL return to IDLE with armed unchanged.
REQ-021 A stop rising edge SHALL return only the ring_ch channel to IDLE; other ringing channels SHALL continue.
REQ-022 A snooze rising edge SHALL move the ring_ch channel to SNOOZE with a wake time of its own time plus SNOOZE_MIN minutes, wrapping 59->0 with hour carry and hour 23->0.
REQ-023 SNOOZE->RINGING when sec_tick=1 and the current time equals the wake time; the ring counter SHALL restart at 0.
REQ-024 A stop rising edge while no channel rings SHALL return every SNOOZE channel to IDLE.
REQ-025 Several channels matching on the same tick SHALL all enter RINGING; ring_ch SHALL select the lowest index.
REQ-026 A write to a channel SHALL force it to IDLE and load time and armed flag on the next edge; writes to other channels SHALL not disturb ringing.
REQ-027 A write with a time field out of range SHALL be ignored entirely.
REQ-028 A simultaneous write and stop/snooze on the same channel: the write SHALL win.
REQ-029 stop and snooze edges in the same cycle: stop SHALL win.

Reset
REQ-030 reset=0 at a clk edge SHALL set all channels to IDLE, times 0:00:00, armed=0, counters 0, edge detectors 0.
REQ-031 reset SHALL clear ring, ring_ch and armed_mask to 0, including in mid-ring and mid-snooze.

Configuration
REQ-032 With macro MULTI_ALARM_SNOOZE_EN defined, snooze SHALL behave as in REQ-022/023/024.
REQ-033 Without MULTI_ALARM_SNOOZE_EN, the snooze input SHALL be ignored, no SNOOZE state or wake registers SHALL exist, and a snooze edge SHALL have no effect.

Structure
REQ-034 Shared package multi_alarm_pkg SHALL hold the channel state enumeration, the 7-bit time field typedef and the constants 23 and 59.
REQ-035 One sub-module alarm_channel SHALL implement a single channel; multi_alarm SHALL instantiate N_CH copies and contain the edge detectors, priority encoder and write decode.

Verification
REQ-036 Write ch0=07:30:00 armed; drive time to 07:30:00 with tick -> ring=1 next cycle, ring_ch=0.
REQ-037 Ring ch2 with RING_SECS=3, no stop -> ring falls after the 3rd tick; armed_mask[2] stays 1.
REQ-038 ch1 and ch3 both at 12:00:00 -> ring_ch=1; stop -> ring_ch=3, ring=1; stop -> ring=0.
REQ-039 SNOOZE_EN, ch0 at 23:58:10, snooze -> re-ring at 00:03:10; without the macro, snooze is ignored and the ring continues.
REQ-040 Assert reset=0 mid-ring -> ring, ring_ch and armed_mask are 0 after the edge; a write with wr_min=60 leaves the channel unchanged.
